// File: rtl/axis_rr_packet_scheduler.sv
// Round-robin AXI-Stream packet scheduler: arbitrates N requesters onto one output,
// holding the grant for a whole packet and latching the header's mesh destination.
module axis_rr_packet_scheduler #(
    parameter int unsigned CHANNEL_NUMBER = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_ROUTERS_X  = 4,
    parameter int unsigned MAX_ROUTERS_Y  = 4,
    localparam int unsigned GW = $clog2(CHANNEL_NUMBER),
    localparam int unsigned XW = $clog2(MAX_ROUTERS_X),
    localparam int unsigned YW = $clog2(MAX_ROUTERS_Y)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [CHANNEL_NUMBER-1:0]            in_tvalid_i,
    input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata_i,
    input  logic [CHANNEL_NUMBER-1:0]            in_tlast_i,
    output logic [CHANNEL_NUMBER-1:0]            in_tready_o,
    output logic                                 out_tvalid_o,
    output logic [DATA_WIDTH-1:0]                out_tdata_o,
    output logic                                 out_tlast_o,
    input  logic                                 out_tready_i,
    output logic [GW-1:0]                        grant_o,
    output logic [XW-1:0]                        target_x_o,
    output logic [YW-1:0]                        target_y_o,
    output logic                                 busy_o,
    output logic [15:0]                          pkt_cnt_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [XW-1:0]   target_x_q, target_x_d;
    logic [YW-1:0]   target_y_q, target_y_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;

    logic [GW-1:0]         winner;
    logic                  found;
    logic [GW-1:0]         idx;
    logic [DATA_WIDTH-1:0] header;

    // Search upward from the requester after the last winner, wrapping modulo N.
    always_comb begin
        winner = last_grant_q;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= CHANNEL_NUMBER; i++) begin
            idx = GW'((32'(last_grant_q) + i) % CHANNEL_NUMBER);
            if (!found && in_tvalid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign header = in_tdata_i[32'(winner) * DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        target_x_d   = target_x_q;
        target_y_d   = target_y_q;
        pkt_cnt_d    = pkt_cnt_q;
        out_tvalid_o = 1'b0;
        out_tlast_o  = 1'b0;
        out_tdata_o  = in_tdata_i[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        in_tready_o  = '0;
        unique case (state_q)
            StIdle: begin
                // Header is only inspected here; it is consumed in the first busy cycle.
                if (|in_tvalid_i) begin
                    state_d      = StBusy;
                    grant_d      = winner;
                    last_grant_d = winner;
                    target_x_d   = header[XW-1:0];
                    target_y_d   = header[XW+YW-1:XW];
                end
            end
            StBusy: begin
                out_tvalid_o         = in_tvalid_i[grant_q];
                out_tlast_o          = in_tlast_i[grant_q];
                in_tready_o[grant_q] = out_tready_i;
                if (out_tvalid_o && out_tready_i && out_tlast_o) begin
                    state_d   = StIdle;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GW'(CHANNEL_NUMBER - 1);
            target_x_q   <= '0;
            target_y_q   <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            target_x_q   <= target_x_d;
            target_y_q   <= target_y_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign grant_o    = grant_q;
    assign target_x_o = target_x_q;
    assign target_y_o = target_y_q;
    assign busy_o     = (state_q == StBusy);
    assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_packet_scheduler.sv
// Directed and scoreboarded bench for the round-robin packet scheduler.
module tb_axis_rr_packet_scheduler;

    localparam int N  = 5;
    localparam int DW = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      in_tvalid_i;
    logic [N*DW-1:0]   in_tdata_i;
    logic [N-1:0]      in_tlast_i;
    logic [N-1:0]      in_tready_o;
    logic              out_tvalid_o;
    logic [DW-1:0]     out_tdata_o;
    logic              out_tlast_o;
    logic              out_tready_i;
    logic [2:0]        grant_o;
    logic [1:0]        target_x_o;
    logic [1:0]        target_y_o;
    logic              busy_o;
    logic [15:0]       pkt_cnt_o;

    always #5 clk_i = ~clk_i;

    axis_rr_packet_scheduler #(
        .CHANNEL_NUMBER(N),
        .DATA_WIDTH    (DW),
        .MAX_ROUTERS_X (4),
        .MAX_ROUTERS_Y (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_tvalid_i (in_tvalid_i),
        .in_tdata_i  (in_tdata_i),
        .in_tlast_i  (in_tlast_i),
        .in_tready_o (in_tready_o),
        .out_tvalid_o(out_tvalid_o),
        .out_tdata_o (out_tdata_o),
        .out_tlast_o (out_tlast_o),
        .out_tready_i(out_tready_i),
        .grant_o     (grant_o),
        .target_x_o  (target_x_o),
        .target_y_o  (target_y_o),
        .busy_o      (busy_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packet sources: each requester emits packets whose beats encode {ch, pkt, beat}.
    logic [N-1:0] src_en, hold;
    int  pkt_no[N];
    int  beat_no[N];
    int  quota, len_fix;
    bit  gen_mode, sb_on;

    // Scoreboard with its own round-robin model.
    bit  sb_busy;
    int  sb_ch, sb_last, sb_beat;
    int  sb_pkt[N];

    function automatic int pkt_len(input int ch, input int p);
        if (len_fix != 0) return len_fix;
        return ((ch + 3 * p) % 4) + 1;
    endfunction

    function automatic logic [31:0] mk_data(input int ch, input int p, input int b);
        return {8'(ch), 8'(p), 16'(b)};
    endfunction

    function automatic int rr_pick();
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (sb_last + i) % N;
            if (src_en[k] && sb_pkt[k] < quota) return k;
        end
        return -1;
    endfunction

    task automatic drive_sources();
        for (int k = 0; k < N; k++) begin
            in_tvalid_i[k]          = src_en[k] && !hold[k] && (pkt_no[k] < quota);
            in_tdata_i[k*DW +: DW]  = mk_data(k, pkt_no[k], beat_no[k]);
            in_tlast_i[k]           = (beat_no[k] == pkt_len(k, pkt_no[k]) - 1);
        end
    endtask

    task automatic sb_beat_check();
        logic last_exp;
        if (!sb_busy) begin
            sb_ch   = rr_pick();
            sb_busy = 1'b1;
            sb_beat = 0;
            if (sb_ch < 0) begin
                check("sb_spurious_beat", 32'd1, 32'd0);
                sb_busy = 1'b0;
                return;
            end
            sb_last = sb_ch;
            check("sb_grant", 32'(grant_o), 32'(sb_ch));
        end
        last_exp = (sb_beat == pkt_len(sb_ch, sb_pkt[sb_ch]) - 1);
        check("sb_data", out_tdata_o, mk_data(sb_ch, sb_pkt[sb_ch], sb_beat));
        check("sb_last", 32'(out_tlast_o), 32'(last_exp));
        if (last_exp) begin
            sb_busy = 1'b0;
            sb_pkt[sb_ch]++;
            sb_beat = 0;
        end else begin
            sb_beat++;
        end
    endtask

    task automatic step();
        logic [N-1:0] hs;
        #1;
        hs = in_tvalid_i & in_tready_o;
        if (sb_on && out_tvalid_o && out_tready_i) sb_beat_check();
        @(posedge clk_i);
        #1;
        if (gen_mode) begin
            for (int k = 0; k < N; k++) begin
                if (hs[k]) begin
                    if (beat_no[k] == pkt_len(k, pkt_no[k]) - 1) begin
                        beat_no[k] = 0;
                        pkt_no[k]++;
                    end else begin
                        beat_no[k]++;
                    end
                end
            end
            drive_sources();
        end
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        in_tvalid_i = '0;
        in_tdata_i  = '0;
        in_tlast_i  = '0;
        src_en      = '0;
        hold        = '0;
        sb_busy     = 1'b0;
        sb_last     = N - 1;
        for (int k = 0; k < N; k++) begin
            pkt_no[k]  = 0;
            beat_no[k] = 0;
            sb_pkt[k]  = 0;
        end
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic wait_busy(input logic v);
        int t;
        t = 0;
        while (busy_o !== v && t < 100) begin
            step();
            t++;
        end
        if (busy_o !== v) check("busy_timeout", 32'(busy_o), 32'(v));
    endtask

    initial begin
        int exp_g[6];
        int t, total;
        exp_g = '{0, 1, 2, 3, 4, 0};
        out_tready_i = 1'b1;
        gen_mode     = 1'b0;
        sb_on        = 1'b0;
        quota        = 1000;
        len_fix      = 0;
        in_tvalid_i  = '0;
        in_tdata_i   = '0;
        in_tlast_i   = '0;
        src_en       = '0;
        hold         = '0;

        // Reset values, visible before any clock edge.
        rst_i = 1'b1;
        #1;
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cnt", 32'(pkt_cnt_o), 32'd0);
        check("rst_tvalid", 32'(out_tvalid_o), 32'd0);
        check("rst_tready", 32'(in_tready_o), 32'd0);
        check("rst_tx", 32'(target_x_o), 32'd0);
        check("rst_ty", 32'(target_y_o), 32'd0);
        do_reset();

        // 3-beat packet on requester 2, header 9 -> x=1, y=2.
        in_tvalid_i = 5'b00100;
        in_tdata_i[2*DW +: DW] = 32'h0000_0009;
        in_tlast_i = '0;
        #1;
        check("bubble_busy", 32'(busy_o), 32'd0);
        check("bubble_tvalid", 32'(out_tvalid_o), 32'd0);
        check("bubble_tready", 32'(in_tready_o), 32'd0);
        step();
        check("p1_grant", 32'(grant_o), 32'd2);
        check("p1_tx", 32'(target_x_o), 32'd1);
        check("p1_ty", 32'(target_y_o), 32'd2);
        check("p1_busy", 32'(busy_o), 32'd1);
        check("p1_hdr", out_tdata_o, 32'h0000_0009);
        check("p1_tready", 32'(in_tready_o), 32'b00100);
        step();
        in_tdata_i[2*DW +: DW] = 32'h0000_00A1;
        #1;
        check("p1_b1", out_tdata_o, 32'h0000_00A1);
        check("p1_b1_last", 32'(out_tlast_o), 32'd0);
        step();
        in_tdata_i[2*DW +: DW] = 32'h0000_00A2;
        in_tlast_i = 5'b00100;
        #1;
        check("p1_b2", out_tdata_o, 32'h0000_00A2);
        check("p1_b2_last", 32'(out_tlast_o), 32'd1);
        step();
        in_tvalid_i = '0;
        in_tlast_i  = '0;
        #1;
        check("p1_done_busy", 32'(busy_o), 32'd0);
        check("p1_cnt", 32'(pkt_cnt_o), 32'd1);
        check("p1_grant_hold", 32'(grant_o), 32'd2);
        check("p1_tx_hold", 32'(target_x_o), 32'd1);

        // All requesters continuously sending 2-beat packets.
        do_reset();
        gen_mode = 1'b1;
        len_fix  = 2;
        src_en   = '1;
        drive_sources();
        for (int i = 0; i < 6; i++) begin
            wait_busy(1'b1);
            check("rr_grant", 32'(grant_o), 32'(exp_g[i]));
            wait_busy(1'b0);
        end
        check("rr_cnt", 32'(pkt_cnt_o), 32'd6);

        // Requester 1 stalls mid-packet; requester 3 must wait.
        do_reset();
        len_fix = 4;
        src_en  = 5'b01010;
        drive_sources();
        wait_busy(1'b1);
        check("stall_grant0", 32'(grant_o), 32'd1);
        step();
        step();
        hold[1] = 1'b1;
        drive_sources();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_grant", 32'(grant_o), 32'd1);
            check("stall_busy", 32'(busy_o), 32'd1);
            check("stall_tvalid", 32'(out_tvalid_o), 32'd0);
            check("stall_tready", 32'(in_tready_o), 32'b00010);
            step();
        end
        hold = '0;
        drive_sources();
        wait_busy(1'b0);
        check("stall_cnt", 32'(pkt_cnt_o), 32'd1);
        wait_busy(1'b1);
        check("stall_next", 32'(grant_o), 32'd3);

        // 100 random-length packets under random backpressure.
        do_reset();
        len_fix = 0;
        quota   = 20;
        src_en  = '1;
        sb_on   = 1'b1;
        drive_sources();
        t     = 0;
        total = 0;
        while (total < 100 && t < 5000) begin
            out_tready_i = 1'($urandom_range(0, 1));
            step();
            total = 0;
            for (int k = 0; k < N; k++) total += sb_pkt[k];
            t++;
        end
        sb_on        = 1'b0;
        out_tready_i = 1'b1;
        check("rand_total", 32'(total), 32'd100);
        check("rand_cnt", 32'(pkt_cnt_o), 32'd100);
        for (int k = 0; k < N; k++) check("rand_per_ch", 32'(sb_pkt[k]), 32'd20);

        // Reset during beat 2 of a 5-beat packet on requester 4.
        do_reset();
        quota   = 1000;
        len_fix = 5;
        src_en  = 5'b10000;
        drive_sources();
        wait_busy(1'b1);
        check("ar_grant", 32'(grant_o), 32'd4);
        step();
        #2;
        rst_i = 1'b1;
        #1;
        check("ar_busy", 32'(busy_o), 32'd0);
        check("ar_tvalid", 32'(out_tvalid_o), 32'd0);
        check("ar_tready", 32'(in_tready_o), 32'd0);
        check("ar_grant_rst", 32'(grant_o), 32'd0);
        check("ar_cnt", 32'(pkt_cnt_o), 32'd0);
        do_reset();
        len_fix = 2;
        src_en  = 5'b10001;
        drive_sources();
        wait_busy(1'b1);
        check("ar_first", 32'(grant_o), 32'd0);

        // Counter wrap with single-beat packets.
        do_reset();
        force dut.pkt_cnt_q = 16'hFFFE;
        #1;
        release dut.pkt_cnt_q;
        check("wrap_preload", 32'(pkt_cnt_o), 32'hFFFE);
        len_fix = 1;
        src_en  = 5'b00001;
        drive_sources();
        wait_busy(1'b1);
        step();
        check("single_beat_done", 32'(busy_o), 32'd0);
        check("wrap_ffff", 32'(pkt_cnt_o), 32'hFFFF);
        wait_busy(1'b1);
        step();
        check("wrap_zero", 32'(pkt_cnt_o), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_rr_packet_scheduler.md
AXIS_RR_PACKET_SCHEDULER -- requirements
Module: axis_rr_packet_scheduler

Interface
REQ-001 Parameter CHANNEL_NUMBER, default 5: number of requesting AXI-Stream inputs (N, N >= 2).
REQ-002 Parameter DATA_WIDTH, default 32: tdata width in bits.
REQ-003 Parameter MAX_ROUTERS_X, default 4: mesh X size; XW = $clog2(MAX_ROUTERS_X).
REQ-004 Parameter MAX_ROUTERS_Y, default 4: mesh Y size; YW = $clog2(MAX_ROUTERS_Y).
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 in_tvalid_i  input  N  per-requester valid.
REQ-008 in_tdata_i  input  N*DATA_WIDTH  per-requester data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_tlast_i  input  N  per-requester end-of-packet.
REQ-010 in_tready_o  output  N  per-requester ready.
REQ-011 out_tvalid_o / out_tdata_o / out_tlast_o  output  1 / DATA_WIDTH / 1  shared output stream.
REQ-012 out_tready_i  input  1  downstream ready.
REQ-013 grant_o  output  $clog2(N)  index of the requester currently owning the output.
REQ-014 target_x_o / target_y_o  output  XW / YW  destination decoded from the granted packet's header flit.
REQ-015 busy_o  output  1  high while a packet owns the output.
REQ-016 pkt_cnt_o  output  16  count of completed packets, wrapping modulo 2^16.

Function
REQ-017 The FSM SHALL have two states: IDLE and BUSY.
REQ-018 In IDLE, if any in_tvalid_i bit is high, the block SHALL grant the first valid index found searching upward (modulo N) from last_grant+1, then enter BUSY on the next edge.
REQ-019 On the grant edge, grant_o SHALL load the winner index, and last_grant SHALL load the same index.
REQ-020 On the grant edge, target_x_o SHALL load the winner's header tdata[XW-1:0], and target_y_o SHALL load tdata[XW+YW-1:XW].
REQ-021 In IDLE, all in_tready_o bits SHALL be 0 and out_tvalid_o SHALL be 0, giving one bubble cycle per packet; the header beat is not consumed in IDLE.
REQ-022 In BUSY, out_tvalid_o, out_tdata_o and out_tlast_o SHALL combinationally equal in_tvalid_i, in_tdata_i and in_tlast_i of the granted requester.
REQ-023 In BUSY, in_tready_o[grant] SHALL equal out_tready_i; all other in_tready_o bits SHALL be 0.
REQ-024 The grant SHALL be held through the whole packet: a handshake with out_tlast_o=1 SHALL return the FSM to IDLE and increment pkt_cnt_o.
REQ-025 If the granted requester deasserts tvalid mid-packet, the block SHALL hold the grant and stay in BUSY; no other requester may preempt it.
REQ-026 A single-beat packet (tlast on the header) SHALL complete in one BUSY cycle when out_tready_i=1.
REQ-027 With only one active requester, it SHALL be regranted after each bubble cycle.
REQ-028 With all N requesters continuously valid, grants SHALL rotate 0,1,...,N-1,0 with no starvation.
REQ-029 grant_o, target_x_o and target_y_o SHALL hold their last values in IDLE until the next grant.
REQ-030 busy_o SHALL be 1 exactly when the FSM is in BUSY.
REQ-031 pkt_cnt_o SHALL wrap from 16'hFFFF to 0 without any flag.

Reset
REQ-032 While rst_i=1, the following SHALL hold regardless of clock: FSM=IDLE; grant_o=0; last_grant=N-1 (so requester 0 has first priority); target_x_o=0; target_y_o=0; pkt_cnt_o=0; busy_o=0; out_tvalid_o=0; all in_tready_o=0.
REQ-033 Reset asserted mid-packet SHALL abandon that packet immediately, with no increment of pkt_cnt_o; after release, arbitration restarts from requester 0.

Verification
REQ-034 Reset, then a 3-beat packet on requester 2 with header 32'h0000_0009 -> one bubble cycle; then grant_o=2, target_x_o=1, target_y_o=2, 3 output beats, busy_o drops after tlast, pkt_cnt_o=1.
REQ-035 All 5 requesters continuously sending 2-beat packets -> grant order 0,1,2,3,4,0 and pkt_cnt_o=6 after 6 packets.
REQ-036 Requester 1 granted with a 4-beat packet, in_tvalid_i[1] low for 3 cycles mid-packet, requester 3 valid throughout -> grant stays 1 until its tlast, then requester 3 is granted.
REQ-037 Random out_tready_i backpressure (50%) on 100 random packets -> scoreboard shows each packet's beats contiguous and in order, with no loss or duplication.
REQ-038 Reset asserted during beat 2 of a 5-beat packet on requester 4 -> outputs take reset values asynchronously; after release, with requesters 0 and 4 valid, requester 0 is granted first.
REQ-039 pkt_cnt_o preloaded near wrap, 2 single-beat packets sent -> sequence 16'hFFFF, 16'h0000.
